mips_fetch_stage: RTL and testbench
===================================

Name: mips_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 32-bit 5-stage MIPS core; sits directly upstream of decode.
- Owns the PC and drives the byte address to the combinational-read instruction memory.
- Captures the returned word into the IF/ID pipeline register.
- Honours hazard stall, pipeline flush and branch/jump redirect from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word injected into IF/ID on flush/redirect (sll $0,$0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- inst_mem_rd_addr_to_instmem  out  32  byte address to instruction memory; equals PC.
- instruction_i  in  32  instruction word returned combinationally for the current address.
- stall_i  in  1  load-use hazard; hold PC and IF/ID.
- flush_i  in  1  squash IF/ID contents.
- redirect_i  in  1  taken branch/jump; load redirect_pc_i into PC.
- redirect_pc_i  in  32  branch/jump target byte address.
- ifid_instr_o  out  32  IF/ID instruction.
- ifid_pc_plus4_o  out  32  IF/ID PC+4 of that instruction.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- fetch_count_o  out  32  count of instructions accepted into IF/ID.
- misalign_err_o  out  1  sticky: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rst_n low, async, any time including mid-operation):
  - PC = RESET_PC; ifid_instr_o = NOP_INSTR; ifid_pc_plus4_o = 0; ifid_valid_o = 0; fetch_count_o = 0; misalign_err_o = 0.
- Address path: inst_mem_rd_addr_to_instmem = PC register, driven directly with no extra logic; instruction_i is sampled in the same cycle.
- Per-edge PC update, priority redirect_i > stall_i > advance:
  - redirect_i: PC <= {redirect_pc_i[31:2],2'b00}. If redirect_pc_i[1:0] != 0, misalign_err_o <= 1, cleared only by reset.
  - stall_i (no redirect): PC holds.
  - otherwise: PC <= PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Per-edge IF/ID update, priority (flush_i | redirect_i) > stall_i > capture:
  - flush or redirect: ifid_instr_o <= NOP_INSTR; ifid_pc_plus4_o <= 0; ifid_valid_o <= 0.
  - stall only: all IF/ID outputs hold.
  - capture: ifid_instr_o <= instruction_i; ifid_pc_plus4_o <= PC + 4; ifid_valid_o <= 1.
- Latency: the word at address A is on ifid_instr_o exactly one edge after PC == A; steady-state throughput is one instruction per clock.
- fetch_count_o increments by 1 on each capture edge only; it does not count on stall, flush or redirect edges. It wraps 32'hFFFF_FFFF -> 0.
- Stall plus flush in the same cycle: PC holds and IF/ID is squashed.
- Redirect plus stall in the same cycle: redirect wins and PC loads the target.
- First rising edge after rst_n deassertion fetches RESET_PC; ifid_valid_o rises on that edge unless stall, flush or redirect is active.
- No combinational path from any input to any IF/ID output. The only combinational output is the address, which depends on PC alone.

Test Plan:
- Reset release, memory words 0..3 = 0x8C010000, 0x8C020001, 0x8C040002, 0x00221820, no stall -> address steps 0,4,8,12 per clock; ifid_instr_o follows one cycle later; ifid_pc_plus4_o = 4,8,12,16; fetch_count_o = 4 after 4 captures.
- stall_i high for 2 cycles while PC = 8 -> address stays 8; IF/ID holds word 1 with pc_plus4 = 8; fetch_count_o frozen; resumes at 12 afterwards.
- redirect_i with redirect_pc_i = 0x4 while PC = 0x14 -> next address 0x4; IF/ID = NOP, valid 0 for one cycle; word at 0x4 captured on the following edge.
- stall_i and flush_i together at PC = 0x10 -> PC holds 0x10; ifid_valid_o = 0; ifid_instr_o = 0.
- redirect_pc_i = 0x0000_0023 -> PC = 0x20; misalign_err_o = 1 and stays 1 through later redirects until rst_n low.
- rst_n dropped asynchronously mid-clock at PC = 0x18 -> all outputs go to reset values immediately, without a clock edge. Separately, force PC = 0xFFFF_FFFC and advance -> PC wraps to 0 and ifid_pc_plus4_o = 0.

Source files
------------

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS core: owns the PC, addresses the
// instruction memory and registers the returned word into the IF/ID register.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] inst_mem_rd_addr_to_instmem,
    input  logic [31:0] instruction_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic        ifid_valid_o,
    output logic [31:0] fetch_count_o,
    output logic        misalign_err_o
);

    typedef enum logic [1:0] {
        IFID_CAPTURE,
        IFID_HOLD,
        IFID_SQUASH
    } ifid_action_e;

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic         misalign_err_q, misalign_err_d;
    logic [31:0]  pc_plus4;
    ifid_action_e ifid_action;

    // Wraps naturally at 2^32, so 32'hFFFF_FFFC advances to zero.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        pc_d           = pc_q;
        misalign_err_d = misalign_err_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
            if (redirect_pc_i[1:0] != 2'b00) begin
                misalign_err_d = 1'b1;
            end
        end else if (!stall_i) begin
            pc_d = pc_plus4;
        end
    end

    // A squash beats a stall so a bubble is inserted even while the PC holds.
    always_comb begin
        ifid_action = IFID_CAPTURE;
        if (flush_i || redirect_i) begin
            ifid_action = IFID_SQUASH;
        end else if (stall_i) begin
            ifid_action = IFID_HOLD;
        end
    end

    always_comb begin
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_valid_d    = ifid_valid_q;
        fetch_count_d   = fetch_count_q;
        unique case (ifid_action)
            IFID_SQUASH: begin
                ifid_instr_d    = NOP_INSTR;
                ifid_pc_plus4_d = 32'd0;
                ifid_valid_d    = 1'b0;
            end
            IFID_CAPTURE: begin
                ifid_instr_d    = instruction_i;
                ifid_pc_plus4_d = pc_plus4;
                ifid_valid_d    = 1'b1;
                fetch_count_d   = fetch_count_q + 32'd1;
            end
            default: ;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_plus4_q <= 32'd0;
            ifid_valid_q    <= 1'b0;
            fetch_count_q   <= 32'd0;
            misalign_err_q  <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_count_q   <= fetch_count_d;
            misalign_err_q  <= misalign_err_d;
        end
    end

    assign inst_mem_rd_addr_to_instmem = pc_q;
    assign ifid_instr_o                = ifid_instr_q;
    assign ifid_pc_plus4_o             = ifid_pc_plus4_q;
    assign ifid_valid_o                = ifid_valid_q;
    assign fetch_count_o               = fetch_count_q;
    assign misalign_err_o              = misalign_err_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed scenarios plus random
// stall/flush/redirect traffic compared every cycle against a behavioural model.
module tb_mips_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] instruction;
    logic        stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr, ifid_pc_plus4, fetch_count;
    logic        ifid_valid, misalign_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    logic [31:0] imem [0:63];

    mips_fetch_stage dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .inst_mem_rd_addr_to_instmem (addr),
        .instruction_i               (instruction),
        .stall_i                     (stall),
        .flush_i                     (flush),
        .redirect_i                  (redirect),
        .redirect_pc_i               (redirect_pc),
        .ifid_instr_o                (ifid_instr),
        .ifid_pc_plus4_o             (ifid_pc_plus4),
        .ifid_valid_o                (ifid_valid),
        .fetch_count_o               (fetch_count),
        .misalign_err_o              (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Low 256 bytes come from the table; any other address returns its own inverse.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:8] == 24'd0) return imem[a[7:2]];
        return ~a;
    endfunction

    assign instruction = mem_word(addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the architectural state of the stage as plain variables.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'd0; m_instr <= 32'd0; m_pc4 <= 32'd0;
            m_valid <= 1'b0; m_count <= 32'd0; m_err <= 1'b0;
        end else begin
            bit squashed, captured;
            squashed = flush || redirect;
            captured = !squashed && !stall;
            m_pc  <= redirect ? (redirect_pc & 32'hFFFF_FFFC)
                   : stall    ? m_pc : m_pc + 32'd4;
            m_err <= m_err || (redirect && (redirect_pc % 4 != 0));
            if (squashed) begin
                m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
            end else if (captured) begin
                m_instr <= mem_word(m_pc); m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
                m_count <= m_count + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("addr",        addr,                  m_pc);
            check("ifid_instr",  ifid_instr,            m_instr);
            check("ifid_pc4",    ifid_pc_plus4,         m_pc4);
            check("ifid_valid",  {31'd0, ifid_valid},   {31'd0, m_valid});
            check("fetch_count", fetch_count,           m_count);
            check("misalign",    {31'd0, misalign_err}, {31'd0, m_err});
        end
    end

    task automatic drive(input bit st, input bit fl, input bit rd, input logic [31:0] rpc);
        stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
    endtask

    // Apply inputs for one edge, then land on the following falling edge.
    task automatic step(input bit st, input bit fl, input bit rd, input logic [31:0] rpc);
        drive(st, fl, rd, rpc);
        @(negedge clk);
    endtask

    initial begin
        imem[0] = 32'h8C01_0000;
        imem[1] = 32'h8C02_0001;
        imem[2] = 32'h8C04_0002;
        imem[3] = 32'h0022_1820;
        for (int i = 4; i < 64; i++) imem[i] = $urandom;

        rst_n = 1'b0;
        drive(0, 0, 0, 32'd0);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_addr",  addr, 32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_count", fetch_count, 32'd0);

        // Sequential fetch of words 0..3
        rst_n = 1'b1;
        check("start_addr", addr, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 32'd0);
            check("seq_addr",  addr,          32'(4 * i));
            check("seq_instr", ifid_instr,    imem[i - 1]);
            check("seq_pc4",   ifid_pc_plus4, 32'(4 * i));
        end
        check("seq_count", fetch_count, 32'd4);
        check("seq_last",  ifid_instr,   32'h0022_1820);

        // Stall two cycles with PC = 8 holding word 1
        step(0, 0, 1, 32'h4);
        check("rd_nop_valid", {31'd0, ifid_valid}, 32'd0);
        step(0, 0, 0, 32'd0);
        check("pre_stall_addr", addr, 32'd8);
        step(1, 0, 0, 32'd0);
        step(1, 0, 0, 32'd0);
        check("stall_addr",  addr,          32'd8);
        check("stall_instr", ifid_instr,    32'h8C02_0001);
        check("stall_pc4",   ifid_pc_plus4, 32'd8);
        check("stall_count", fetch_count,   32'd5);
        step(0, 0, 0, 32'd0);
        check("resume_addr",  addr,       32'd12);
        check("resume_instr", ifid_instr, 32'h8C04_0002);

        // Redirect at PC = 0x14 back to 0x4
        step(0, 0, 0, 32'd0);
        step(0, 0, 0, 32'd0);
        check("at_0x14", addr, 32'h14);
        step(0, 0, 1, 32'h4);
        check("redir_addr",  addr,       32'h4);
        check("redir_instr", ifid_instr, 32'd0);
        step(0, 0, 0, 32'd0);
        check("redir_capture", ifid_instr, 32'h8C02_0001);

        // Stall and flush together at PC = 0x10
        step(0, 0, 1, 32'hC);
        step(0, 0, 0, 32'd0);
        check("sf_pre_valid", {31'd0, ifid_valid}, 32'd1);
        step(1, 1, 0, 32'd0);
        check("sf_addr",  addr,                32'h10);
        check("sf_valid", {31'd0, ifid_valid}, 32'd0);
        check("sf_instr", ifid_instr,          32'd0);

        // Misaligned redirect target sets the sticky error
        step(0, 0, 1, 32'h23);
        check("mis_addr", addr, 32'h20);
        check("mis_err",  {31'd0, misalign_err}, 32'd1);
        step(1, 0, 1, 32'h8);
        check("mis_sticky", {31'd0, misalign_err}, 32'd1);
        check("rd_over_stall", addr, 32'h8);

        // Random traffic within the table region
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, tgt);
        end

        // PC wrap from 0xFFFF_FFFC
        step(0, 0, 1, 32'hFFFF_FFFC);
        check("wrap_pre", addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'd0);
        check("wrap_addr",  addr,          32'd0);
        check("wrap_pc4",   ifid_pc_plus4, 32'd0);
        check("wrap_instr", ifid_instr,    32'h0000_0003);

        // Asynchronous reset while the clock is high, PC = 0x18
        step(0, 0, 1, 32'h18);
        step(0, 0, 0, 32'd0);
        drive(0, 0, 1, 32'h18);
        @(posedge clk);
        drive(0, 0, 0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr",  addr,                  32'd0);
        check("arst_instr", ifid_instr,            32'd0);
        check("arst_pc4",   ifid_pc_plus4,         32'd0);
        check("arst_valid", {31'd0, ifid_valid},   32'd0);
        check("arst_count", fetch_count,           32'd0);
        check("arst_err",   {31'd0, misalign_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step($urandom_range(0, 3) == 0, 0, 0, 32'd0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
